instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the 10-bit CPU. It owns the program counter and instruction register and handshakes with instruction and data memory. It feeds the IR to the combinational control unit and consumes that unit's decode outputs (fetch_op, jump_control, jmp_addr, ldst_en, wr_en). It gates the register-file write so each instruction commits exactly once, in WB.

Parameters:
DATA_W, 10, instruction/address/data width
RESET_PC, 10'h000, PC value loaded on reset
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid, one-cycle pulse
imem_rdata  in  DATA_W  fetched instruction
ir  out  DATA_W  instruction register, drives control unit instr
fetch_op  in  2  decode: 0 seq, 1 branch/jump, 2 jump-register, 3 halt
jump_control  in  1  decode: unconditional jump/jal
jmp_addr  in  DATA_W  decode: sign-extended PC offset
jr_target  in  DATA_W  register value for fetch_op 2
br_cond  in  1  datapath branch condition
ldst_en  in  2  decode: [1] memory access, [0] 1=store 0=load
wr_en_dec  in  1  decode register-write enable
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write strobe, valid with dmem_req
dmem_ack  in  1  data access complete, one-cycle pulse
rf_we  out  1  gated register-file write enable
pc  out  DATA_W  current PC (link value for jal = pc+1, formed in datapath)
state  out  3  current FSM state, debug
halted  out  1  processor halted
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, ir=0, imem_req=dmem_req=dmem_we=rf_we=0, halted=0, instr_count=0. Reset mid-MEM or mid-FETCH drops the request in the same instant; the outstanding ack is ignored.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Outputs are Moore, decoded from registered state.
- IDLE: run=1 -> FETCH next cycle.
- FETCH: imem_req=1, held until imem_ack. On ack: ir<=imem_rdata, -> DECODE. Ack in any other state is ignored.
- DECODE: 1 cycle for decode settling. fetch_op==3 -> HALT; else -> EXEC.
- EXEC: 1 cycle for ALU settling. ldst_en[1]=1 -> MEM; else -> WB.
- MEM: dmem_req=1, dmem_we=ldst_en[0], held stable until dmem_ack -> WB. No timeout; a stall is unbounded.
- WB: rf_we=wr_en_dec for exactly this cycle. PC update at end of WB:
  - fetch_op 0: pc+1.
  - fetch_op 1: if jump_control | br_cond, pc+jmp_addr; else pc+1.
  - fetch_op 2: jr_target.
  - All arithmetic is modulo 2^DATA_W (3FF+1=000; 002+3FE=000).
  - instr_count += 1, saturating at all-ones.
  - Next state: run=1 -> FETCH, run=0 -> IDLE.
- HALT: halted=1 and all strobes 0. Terminal until rst; run is ignored. The halt instruction is not counted and pc is not advanced.
- Minimum latency per non-memory instruction = FETCH(1+imem wait) + 3 cycles. Back-to-back with 0-wait ack: 4 cycles.
- Deasserting run mid-instruction completes the instruction through WB, then stops in IDLE.
- rf_we is never asserted outside WB, regardless of wr_en_dec.

Decomposition:
- Shared package (cpu_pkg): state encoding constants, fetch_op codes (FOP_SEQ, FOP_BR, FOP_JR, FOP_HALT), ldst_en bit positions, DATA_W.
- One natural sub-module: pc_next_unit, the combinational next-PC mux/adder (fetch_op, jump_control, br_cond, jmp_addr, jr_target, pc -> pc_next). The FSM, IR and counter stay in instr_sequencer.

Test Plan:
1. Reset, run=1, imem_ack 1 cycle after each req, 3 sequential ALU instrs (fetch_op 0, wr_en_dec 1) -> pc 000->001->002->003; one rf_we pulse per instr, in WB only; instr_count=3; 4-cycle spacing.
2. Branch at pc=005, jmp_addr=3FE, jump_control 0: br_cond=0 -> pc 006; br_cond=1 -> pc 003. Jump at pc=3FF with jmp_addr=001, jump_control=1 -> pc 000 (wrap).
3. Load (ldst_en=2'b10) with dmem_ack after 5 cycles -> dmem_req high exactly 5 cycles, dmem_we=0, rf_we one cycle after ack; store (2'b11) -> dmem_we=1, rf_we=0 when wr_en_dec=0.
4. fetch_op 2 with jr_target=1A5 -> pc=1A5; halt instr (fetch_op 3) at pc=010 -> halted=1, pc stays 010, count unchanged, further run/ack pulses ignored.
5. run dropped during MEM -> instr completes, state=IDLE, count incremented; run reasserted -> FETCH at next pc.
6. rst asserted mid-MEM between clock edges -> dmem_req=0 immediately, pc=RESET_PC, count=0; a late dmem_ack after release causes no transition.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU sequencer.
// Contents: FSM state encoding, fetch_op codes, ldst_en bit positions and
// the machine data width.
package cpu_pkg;

  localparam int CPU_DATA_W = 10;

  // State encoding is architecturally visible on the debug 'state' port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // fetch_op decode codes
  localparam logic [1:0] FOP_SEQ  = 2'd0;
  localparam logic [1:0] FOP_BR   = 2'd1;
  localparam logic [1:0] FOP_JR   = 2'd2;
  localparam logic [1:0] FOP_HALT = 2'd3;

  // ldst_en bit positions
  localparam int LDST_MEM_BIT   = 1;
  localparam int LDST_STORE_BIT = 0;

endpackage

// File: rtl/pc_next_unit.sv
// Combinational next-PC selection.
// Ports:
//   pc_i           current PC
//   fetch_op_i     0 seq, 1 branch/jump, 2 jump-register, 3 halt
//   jump_control_i unconditional jump
//   br_cond_i      datapath branch condition
//   jmp_addr_i     sign-extended PC offset
//   jr_target_i    register target for jump-register
//   pc_next_o      PC for the next instruction (modulo 2^DATA_W)
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic [DATA_W-1:0] pc_i,
  input  logic [1:0]        fetch_op_i,
  input  logic              jump_control_i,
  input  logic              br_cond_i,
  input  logic [DATA_W-1:0] jmp_addr_i,
  input  logic [DATA_W-1:0] jr_target_i,
  output logic [DATA_W-1:0] pc_next_o
);

  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W-1:0] pc_rel;

  // Width-limited adds give the required wraparound for free.
  assign pc_inc = pc_i + DATA_W'(1);
  assign pc_rel = pc_i + jmp_addr_i;

  always_comb begin
    pc_next_o = pc_inc;
    case (fetch_op_i)
      FOP_BR:  pc_next_o = (jump_control_i | br_cond_i) ? pc_rel : pc_inc;
      FOP_JR:  pc_next_o = jr_target_i;
      default: pc_next_o = pc_inc;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 10-bit CPU.
// Owns PC, IR and the retired-instruction counter; handshakes with
// instruction and data memory; gates the register-file write to WB.
// Ports:
//   clk, rst                 clock, async active-high reset
//   run                      1 = execute, 0 = stop at instruction boundary
//   imem_req/ack/rdata       instruction fetch handshake
//   ir                       instruction register to the control unit
//   fetch_op, jump_control,
//   jmp_addr, ldst_en,
//   wr_en_dec                decode outputs from the control unit
//   jr_target, br_cond       datapath inputs for PC selection
//   dmem_req/we/ack          data memory handshake
//   rf_we                    gated register-file write enable
//   pc, state, halted        current PC, debug FSM state, halted flag
//   instr_count              saturating retired-instruction count
// Handshake: a request stays high from entry into FETCH/MEM until the
// cycle in which the matching one-cycle ack is sampled at a rising edge;
// acks arriving in any other state are ignored.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int               DATA_W   = CPU_DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  input  logic [1:0]        fetch_op,
  input  logic              jump_control,
  input  logic [DATA_W-1:0] jmp_addr,
  input  logic [DATA_W-1:0] jr_target,
  input  logic              br_cond,
  input  logic [1:0]        ldst_en,
  input  logic              wr_en_dec,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [DATA_W-1:0] pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q;
  logic [CNT_W-1:0]  cnt_q;

  pc_next_unit #(.DATA_W(DATA_W)) u_pc_next (
    .pc_i           (pc_q),
    .fetch_op_i     (fetch_op),
    .jump_control_i (jump_control),
    .br_cond_i      (br_cond),
    .jmp_addr_i     (jmp_addr),
    .jr_target_i    (jr_target),
    .pc_next_o      (pc_d)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  if (imem_ack) state_d = ST_DECODE;
      ST_DECODE: state_d = (fetch_op == FOP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_d = ldst_en[LDST_MEM_BIT] ? ST_MEM : ST_WB;
      ST_MEM:    if (dmem_ack) state_d = ST_WB;
      ST_WB:     state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state, so an async reset
  // drops every strobe immediately.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_FETCH: imem_req = 1'b1;
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ldst_en[LDST_STORE_BIT];
      end
      ST_WB:    rf_we  = wr_en_dec;
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

  // PC, IR and retired counter. The halt instruction never reaches WB,
  // so it is neither counted nor advances the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (state_q == ST_FETCH && imem_ack) ir_q <= imem_rdata;
      if (state_q == ST_WB) begin
        pc_q <= pc_d;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ir          = ir_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule
